// File: rtl/usr_seq_pkg.sv
// Shared op-codes, USR mode encodings and FSM states for the USR op sequencer.
package usr_seq_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Right-moving ops feed the MSB end; left-moving ops feed the LSB end.
    function automatic logic [1:0] shift_sel(input logic [2:0] op);
        return (op == OP_SHL || op == OP_ROL) ? SEL_SHL : SEL_SHR;
    endfunction

endpackage

// File: rtl/usr_op_sequencer.sv
// Expands one handshaken command into per-cycle controls for the 8-bit universal
// shift register, using the USR contents fed back on a_q for rotates and ASR.
module usr_op_sequencer
    import usr_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic             abort,
    input  logic [WIDTH-1:0] a_q,
    output logic [1:0]       sel,
    output logic             msb_in,
    output logic             lsb_in,
    output logic [WIDTH-1:0] i_data,
    output logic             busy,
    output logic             done
);

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [WIDTH-1:0]   i_data_q, i_data_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fill_q, fill_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            sel_q    <= SEL_HOLD;
            i_data_q <= '0;
            op_q     <= OP_NOP;
            cnt_q    <= '0;
            fill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            i_data_q <= i_data_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
        end
    end

    // sel is registered, so it is decided one cycle ahead from the next state.
    always_comb begin
        state_d  = state_q;
        sel_d    = SEL_HOLD;
        i_data_d = i_data_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    cnt_d  = cmd_count;
                    fill_d = cmd_fill;
                    case (cmd_op)
                        OP_NOP: begin
                            state_d = ST_DONE;
                        end
                        OP_LOAD: begin
                            state_d  = ST_EXEC;
                            sel_d    = SEL_LOAD;
                            i_data_d = cmd_data;
                        end
                        OP_CLEAR: begin
                            state_d  = ST_EXEC;
                            sel_d    = SEL_LOAD;
                            i_data_d = '0;
                        end
                        default: begin
                            if (cmd_count == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_EXEC;
                                sel_d   = shift_sel(cmd_op);
                            end
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (op_q == OP_LOAD || op_q == OP_CLEAR
                             || cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    sel_d = sel_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serial inputs follow a_q combinationally so rotates see the value at this edge.
    always_comb begin
        msb_in = 1'b0;
        lsb_in = 1'b0;
        if (state_q == ST_EXEC) begin
            case (op_q)
                OP_SHR:  msb_in = fill_q;
                OP_SHL:  lsb_in = fill_q;
                OP_ROR:  msb_in = a_q[0];
                OP_ROL:  lsb_in = a_q[WIDTH-1];
                OP_ASR:  msb_in = a_q[WIDTH-1];
                default: ;
            endcase
        end
    end

    assign sel       = sel_q;
    assign i_data    = i_data_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_usr_op_sequencer.sv
// Bench: sequencer driving a behavioural 8-bit USR, checked against a queue-based
// schedule model plus directed literal expectations.
module tb_usr_op_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_count = 4'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_fill = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] usr;
    logic [1:0] sel;
    logic       msb_in, lsb_in;
    logic [7:0] i_data;
    logic       busy, done;

    int tests = 0;
    int fails = 0;
    bit rnd_on = 1'b0;

    always #5 clk = ~clk;

    usr_op_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .cmd_fill  (cmd_fill),
        .abort     (abort),
        .a_q       (usr),
        .sel       (sel),
        .msb_in    (msb_in),
        .lsb_in    (lsb_in),
        .i_data    (i_data),
        .busy      (busy),
        .done      (done)
    );

    // The shift register being controlled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) usr <= 8'h00;
        else begin
            case (sel)
                2'b01:   usr <= {msb_in, usr[7:1]};
                2'b10:   usr <= {usr[6:0], lsb_in};
                2'b11:   usr <= i_data;
                default: usr <= usr;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] idata;
        logic       done;
    } exp_t;

    exp_t       q[$];
    logic [2:0] m_op = 3'd0;
    logic       m_fill = 1'b0;
    logic [7:0] exp_final = 8'h00;

    function automatic logic [7:0] final_val(input logic [2:0] op, input int n,
                                             input logic [7:0] d, input logic f,
                                             input logic [7:0] a);
        logic [7:0] v;
        int k;
        v = a;
        k = n % 8;
        case (op)
            3'd1: v = d;
            3'd7: v = 8'h00;
            3'd2: for (int i = 0; i < n; i++) v = {f, v[7:1]};
            3'd3: for (int i = 0; i < n; i++) v = {v[6:0], f};
            3'd4: v = (v >> k) | (v << (8 - k));
            3'd5: v = (v << k) | (v >> (8 - k));
            3'd6: v = $signed(v) >>> n;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                q.delete();
            end else if (q.size() != 0) begin
                if (!q[0].done && abort) q.delete();
                else void'(q.pop_front());
            end else if (cmd_valid) begin
                int n;
                logic [1:0] md;
                m_op   = cmd_op;
                m_fill = cmd_fill;
                n      = int'(cmd_count);
                exp_final = final_val(cmd_op, n, cmd_data, cmd_fill, usr);
                md = (cmd_op == 3'd3 || cmd_op == 3'd5) ? 2'b10 : 2'b01;
                case (cmd_op)
                    3'd0: ;
                    3'd1: q.push_back('{sel: 2'b11, idata: cmd_data, done: 1'b0});
                    3'd7: q.push_back('{sel: 2'b11, idata: 8'h00, done: 1'b0});
                    default: for (int i = 0; i < n; i++)
                        q.push_back('{sel: md, idata: 8'h00, done: 1'b0});
                endcase
                q.push_back('{sel: 2'b00, idata: 8'h00, done: 1'b1});
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("rst_sel", sel, 2'b00);
                chk("rst_idata", i_data, 8'h00);
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_ready", cmd_ready, 1'b1);
            end else if (q.size() == 0) begin
                chk("idle_sel", sel, 2'b00);
                chk("idle_ready", cmd_ready, 1'b1);
                chk("idle_busy", busy, 1'b0);
                chk("idle_done", done, 1'b0);
            end else begin
                chk("sel", sel, q[0].sel);
                chk("busy", busy, 1'b1);
                chk("ready", cmd_ready, 1'b0);
                chk("done", done, q[0].done);
                if (q[0].sel == 2'b11) chk("idata", i_data, q[0].idata);
                if (q[0].sel == 2'b01) begin
                    chk("msb_in", msb_in, (m_op == 3'd2) ? m_fill :
                                          (m_op == 3'd4) ? usr[0] : usr[7]);
                    chk("lsb_unused", lsb_in, 1'b0);
                end
                if (q[0].sel == 2'b10) begin
                    chk("lsb_in", lsb_in, (m_op == 3'd3) ? m_fill : usr[7]);
                    chk("msb_unused", msb_in, 1'b0);
                end
                if (q[0].done) chk("usr_final", usr, exp_final);
            end
        end
    end

    // Random abort pulses during the random phase only.
    initial begin
        forever begin
            @(negedge clk);
            if (rnd_on) abort = ($urandom_range(0, 15) == 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] d,
                           input logic f, output int nsel, output int lat);
        nsel = 0;
        lat  = -1;
        @(negedge clk);
        cmd_op = op; cmd_count = cnt; cmd_data = d; cmd_fill = f; cmd_valid = 1'b1;
        chk("dir_ready", cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            if (j > 1) @(negedge clk);
            if (sel != 2'b00) nsel++;
            if (done) begin
                lat = j;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    // Accepts ROR 10 and returns at the negedge of the given EXEC cycle.
    task automatic start_ror10(input int exec_cycle);
        @(negedge clk);
        cmd_op = 3'd4; cmd_count = 4'd10; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (exec_cycle - 1) @(negedge clk);
    endtask

    initial begin
        int ns, lt, guard;
        bit r;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

        run_cmd(3'd1, 4'd0, 8'hA5, 1'b0, ns, lt);
        chk("load_sel_cycles", ns, 1); chk("load_lat", lt, 2); chk("load_val", usr, 8'hA5);

        run_cmd(3'd1, 4'd0, 8'h81, 1'b0, ns, lt);
        run_cmd(3'd4, 4'd3, 8'h00, 1'b0, ns, lt);
        chk("ror3_sel_cycles", ns, 3); chk("ror3_lat", lt, 4); chk("ror3_val", usr, 8'h30);

        run_cmd(3'd1, 4'd0, 8'h96, 1'b0, ns, lt);
        run_cmd(3'd6, 4'd2, 8'h00, 1'b0, ns, lt);
        chk("asr2_val", usr, 8'hE5);

        run_cmd(3'd7, 4'd0, 8'h00, 1'b0, ns, lt);
        chk("clear_val", usr, 8'h00);
        run_cmd(3'd3, 4'd9, 8'h00, 1'b1, ns, lt);
        chk("shl9_sel_cycles", ns, 9); chk("shl9_lat", lt, 10); chk("shl9_val", usr, 8'hFF);

        run_cmd(3'd2, 4'd0, 8'h00, 1'b0, ns, lt);
        chk("shr0_sel_cycles", ns, 0); chk("shr0_lat", lt, 1); chk("shr0_val", usr, 8'hFF);
        run_cmd(3'd0, 4'd5, 8'h00, 1'b0, ns, lt);
        chk("nop_sel_cycles", ns, 0); chk("nop_lat", lt, 1); chk("nop_val", usr, 8'hFF);

        // Abort sampled at the edge closing the third rotate: three shifts land.
        run_cmd(3'd1, 4'd0, 8'h01, 1'b0, ns, lt);
        start_ror10(3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_sel", sel, 2'b00); chk("abort_done", done, 1'b0);
        chk("abort_ready", cmd_ready, 1'b1); chk("abort_val", usr, 8'h20);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end

        run_cmd(3'd1, 4'd0, 8'h01, 1'b0, ns, lt);
        start_ror10(3);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mrst_sel", sel, 2'b00); chk("mrst_idata", i_data, 8'h00);
        chk("mrst_busy", busy, 1'b0); chk("mrst_done", done, 1'b0);
        chk("mrst_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #2 rstn = 1'b1;

        // Randomized commands, sometimes offered while busy and held until taken.
        rnd_on = 1'b1;
        repeat (300) begin
            @(negedge clk);
            cmd_op = 3'($urandom_range(0, 7));
            cmd_count = 4'($urandom_range(0, 15));
            cmd_data = 8'($urandom);
            cmd_fill = 1'($urandom);
            cmd_valid = 1'b1;
            r = cmd_ready;
            guard = 0;
            while (!r && guard < 100) begin
                @(negedge clk);
                r = cmd_ready;
                guard++;
            end
            if (!r) chk("accept_timeout", 0, 1);
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rnd_on = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
